decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter: word_size, 32, datapath width in bits.
REQ-002 Parameter: reg_count, 32, number of architectural registers; register address width 5.
REQ-003 Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset; asynchronous, active-low.
- instruction  input  word_size  instruction word from the fetch stage.
- PC_in  input  word_size  PC_next_normal from the fetch stage.
- valid_in  input  1  instruction is valid this cycle.
- stall  input  1  hold the ID/EX outputs.
- flush  input  1  squash the instruction being captured.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write register index.
- wb_data  input  word_size  write data.
- rs1_data  output  word_size  registered source-1 operand.
- rs2_data  output  word_size  registered source-2 operand.
- imm  output  word_size  registered sign-extended immediate.
- rd  output  5  registered destination index.
- opcode  output  7  registered instruction[6:0].
- funct3  output  3  registered instruction[14:12].
- funct7  output  7  registered instruction[31:25].
- PC_out  output  word_size  registered PC_in.
- valid_out  output  1  registered valid.

Function
REQ-004 The register file SHALL hold reg_count x word_size entries; x0 SHALL read 0 and SHALL ignore writes.
REQ-005 Writes SHALL occur on the rising edge of clk when wb_en=1 and wb_addr!=0, regardless of stall or flush.
REQ-006 Reads SHALL use rs1=instruction[19:15] and rs2=instruction[24:20]; when wb_en=1, wb_addr!=0 and wb_addr equals the read index, the read value SHALL be wb_data (write-first bypass).
REQ-007 imm SHALL be decoded from opcode:
- I-type (0010011, 0000011, 1100111): sext(instr[31:20]).
- S-type (0100011): sext({instr[31:25], instr[11:7]}).
- B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U-type (0110111, 0010111): {instr[31:12], 12'b0}.
- J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode: 0.
REQ-008 Latency SHALL be one cycle: the outputs SHALL reflect the inputs sampled at the preceding rising edge.
REQ-009 On an edge with flush=1, all outputs SHALL become 0, including valid_out=0; flush SHALL take priority over stall.
REQ-010 On an edge with stall=1 and flush=0, all outputs SHALL hold their values; held operands SHALL NOT be refreshed by concurrent writes.
REQ-011 On an edge with stall=0 and flush=0, all outputs SHALL load the decoded values and valid_out SHALL load valid_in.
REQ-012 When valid_in=0, fields SHALL still be captured, but downstream SHALL treat the result as a bubble via valid_out=0.
REQ-013 Decode SHALL be purely combinational between instruction and the ID/EX register; there is no additional internal state.

Reset
REQ-014 When rst=0, all outputs SHALL clear to 0 immediately, without waiting for clk.
REQ-015 When rst=0, all register-file entries SHALL clear to 0.
REQ-016 A reset asserted mid-operation SHALL discard any held or stalled contents.
REQ-017 After rst returns to 1, normal capture SHALL resume on the first rising edge.

Verification
REQ-018 Write then read: wb x5=0x0000_1234, then instruction 0x0002_8113 (addi x2,x5,0), valid_in=1 -> next cycle rs1_data=0x1234, imm=0, rd=2, opcode=0x13, valid_out=1.
REQ-019 Bypass: wb_en=1, wb_addr=5, wb_data=0xDEAD_BEEF in the same cycle as an instruction reading x5 -> rs1_data=0xDEADBEEF after the edge.
REQ-020 Immediates:
- 0xFFF0_0093 (addi x1,x0,-1) -> imm=0xFFFF_FFFF.
- 0xFE00_0EE3 (beq, offset -4) -> imm=0xFFFF_FFFC.
- 0x1234_50B7 (lui) -> imm=0x1234_5000.
- Opcode 0x7F -> imm=0.
REQ-021 x0: wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF, then read x0 -> rs1_data=0.
REQ-022 Stall/flush: load PC_in=0x8 with stall=1 for 2 cycles -> outputs unchanged; then assert flush and stall together -> valid_out=0 and PC_out=0 after the edge.
REQ-023 Async reset: drive rst=0 between clock edges with valid_out=1 -> valid_out=0 and rs1_data=0 without a clock edge; a subsequent read of a previously written register -> 0.

Source files
------------

// File: rtl/decode_unit.sv
// Instruction decode stage: a 32-entry register file with write-first
// bypass, RV32 immediate generation, and the ID/EX pipeline register,
// which supports stall (hold) and flush (clear).
module decode_unit #(
    parameter int word_size = 32,
    parameter int reg_count = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic [word_size-1:0] PC_in,
    input  logic                 valid_in,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [word_size-1:0] wb_data,
    output logic [word_size-1:0] rs1_data,
    output logic [word_size-1:0] rs2_data,
    output logic [word_size-1:0] imm,
    output logic [4:0]           rd,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [word_size-1:0] PC_out,
    output logic                 valid_out
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic [word_size-1:0] rs1_data;
        logic [word_size-1:0] rs2_data;
        logic [word_size-1:0] imm;
        logic [4:0]           rd;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [word_size-1:0] pc;
        logic                 valid;
    } idex_t;

    logic [word_size-1:0] regs_q [reg_count];
    idex_t                idex_q;
    idex_t                idex_d;

    logic [31:0]          ins;
    logic [4:0]           rs1_idx;
    logic [4:0]           rs2_idx;
    logic                 wr_en;
    logic [word_size-1:0] rs1_val;
    logic [word_size-1:0] rs2_val;
    logic signed [31:0]   imm32;

    assign ins     = instruction[31:0];
    assign rs1_idx = ins[19:15];
    assign rs2_idx = ins[24:20];
    assign wr_en   = wb_en && (wb_addr != 5'd0);

    // Register file write port; x0 is never written.
    // NOTE: the register file must clear on reset, so it is built from resettable flops, not a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < reg_count; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Read ports: x0 reads zero, and a same-cycle write to the read index is forwarded.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_idx != 5'd0) begin
            rs1_val = (wr_en && (wb_addr == rs1_idx)) ? wb_data : regs_q[rs1_idx];
        end
        if (rs2_idx != 5'd0) begin
            rs2_val = (wr_en && (wb_addr == rs2_idx)) ? wb_data : regs_q[rs2_idx];
        end
    end

    // Immediate generation, selected by the opcode format.
    always_comb begin
        imm32 = '0;
        unique case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:
                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {ins[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Next ID/EX contents: flush clears, stall holds, otherwise capture the decode.
    // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d.rs1_data = rs1_val;
            idex_d.rs2_data = rs2_val;
            idex_d.imm      = word_size'(imm32);
            idex_d.rd       = ins[11:7];
            idex_d.opcode   = ins[6:0];
            idex_d.funct3   = ins[14:12];
            idex_d.funct7   = ins[31:25];
            idex_d.pc       = PC_in;
            idex_d.valid    = valid_in;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign rs1_data  = idex_q.rs1_data;
    assign rs2_data  = idex_q.rs2_data;
    assign imm       = idex_q.imm;
    assign rd        = idex_q.rd;
    assign opcode    = idex_q.opcode;
    assign funct3    = idex_q.funct3;
    assign funct7    = idex_q.funct7;
    assign PC_out    = idex_q.pc;
    assign valid_out = idex_q.valid;

endmodule

// File: tb/tb_decode_unit.sv
// Directed testbench for decode_unit with a queue-based scoreboard: the driver
// pushes the hand-computed expected ID/EX contents for each edge, and a monitor
// pops and compares them on the following falling edge.
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] PC_in;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] PC_out;
    logic        valid_out;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] pc;
        logic        v;
        int unsigned edge_id;
    } exp_t;

    exp_t sb[$];

    decode_unit #(.word_size(32), .reg_count(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .PC_in       (PC_in),
        .valid_in    (valid_in),
        .stall       (stall),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .rd          (rd),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .PC_out      (PC_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm_v, input logic [4:0] rd_v, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] pc,
                                input logic v);
        exp_t e;
        e.tag = tag; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm_v; e.rd = rd_v;
        e.op = op; e.f3 = f3; e.f7 = f7; e.pc = pc; e.v = v; e.edge_id = 0;
        return e;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic vin,
                         input logic st, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        instruction = ins; PC_in = pc; valid_in = vin;
        stall = st; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    // Called at a falling edge: drive one cycle and queue what must appear after the next rising edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic vin,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        exp_t q;
        apply(ins, pc, vin, st, fl, we, wa, wd);
        q = e;
        q.edge_id = edge_cnt + 1;
        sb.push_back(q);
        @(negedge clk);
    endtask

    // Monitor: compare the registered outputs half a cycle after the edge they belong to.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].edge_id == edge_cnt) begin
                e = sb.pop_front();
                check({e.tag, ".rs1"},   rs1_data,         e.rs1);
                check({e.tag, ".rs2"},   rs2_data,         e.rs2);
                check({e.tag, ".imm"},   imm,              e.imm);
                check({e.tag, ".rd"},    {27'd0, rd},      {27'd0, e.rd});
                check({e.tag, ".op"},    {25'd0, opcode},  {25'd0, e.op});
                check({e.tag, ".f3"},    {29'd0, funct3},  {29'd0, e.f3});
                check({e.tag, ".f7"},    {25'd0, funct7},  {25'd0, e.f7});
                check({e.tag, ".pc"},    PC_out,           e.pc);
                check({e.tag, ".valid"}, {31'd0, valid_out}, {31'd0, e.v});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        check("reset.valid", {31'd0, valid_out}, 32'd0);
        check("reset.rs1",   rs1_data, 32'd0);
        check("reset.pc",    PC_out,   32'd0);
        check("reset.imm",   imm,      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Write x5 while a bubble with an all-zero instruction passes.
        step(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234,
             mk("bubble0", 32'h0, 32'h0, 32'h0, 5'd0, 7'h00, 3'd0, 7'h00, 32'h0, 1'b0));
        // addi x2,x5,0 reads the value written last cycle.
        step(32'h0002_8113, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("wr_rd", 32'h0000_1234, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h4, 1'b1));
        // Same-cycle write to x5 is forwarded.
        step(32'h0002_8113, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF,
             mk("bypass", 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h8, 1'b1));
        step(32'h0002_8113, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("bypass_kept", 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'hC, 1'b1));
        // Writes to x0 are neither forwarded nor stored.
        step(32'h0000_0113, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF,
             mk("x0_bypass", 32'h0, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h10, 1'b1));
        step(32'h0000_0113, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("x0_read", 32'h0, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h14, 1'b1));
        // addi x1,x0,-1 (and write x3 for later rs2 reads).
        step(32'hFFF0_0093, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0BAD_F00D,
             mk("imm_i", 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd1, 7'h13, 3'd0, 7'h7F, 32'h18, 1'b1));
        // beq with offset -4.
        step(32'hFE00_0EE3, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("imm_b", 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd29, 7'h63, 3'd0, 7'h7F, 32'h1C, 1'b1));
        // lui; rs2 field decodes to x3.
        step(32'h1234_50B7, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("imm_u", 32'h0, 32'h0BAD_F00D, 32'h1234_5000, 5'd1, 7'h37, 3'd5, 7'h09, 32'h20, 1'b1));
        // Unknown opcode 0x7F with all ones elsewhere: immediate is zero.
        step(32'hFFFF_FFFF, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("imm_none", 32'h0, 32'h0, 32'h0, 5'd31, 7'h7F, 3'd7, 7'h7F, 32'h24, 1'b1));
        // sw x3,-8(x5).
        step(32'hFE32_AC23, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("imm_s", 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hFFFF_FFF8, 5'd24, 7'h23, 3'd2, 7'h7F, 32'h28, 1'b1));
        // jal x1,+8.
        step(32'h0080_00EF, 32'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("imm_j", 32'h0, 32'h0, 32'h0000_0008, 5'd1, 7'h6F, 3'd0, 7'h00, 32'h2C, 1'b1));

        // Stall: load PC 0x8, then hold for two edges while x5 is rewritten.
        step(32'h0002_8113, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("pre_stall", 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h8, 1'b1));
        step(32'hFFF0_0093, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h5555_5555,
             mk("stall1", 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h8, 1'b1));
        step(32'hFFF0_0093, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("stall2", 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h8, 1'b1));
        // Flush wins over stall.
        step(32'hFFF0_0093, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,
             mk("flush", 32'h0, 32'h0, 32'h0, 5'd0, 7'h00, 3'd0, 7'h00, 32'h0, 1'b0));
        // The write made during the stall is visible now.
        step(32'h0002_8113, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("post_flush", 32'h5555_5555, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h10, 1'b1));

        // Asynchronous reset mid-cycle while stalled.
        apply(32'h0002_8113, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        check("pre_reset.valid", {31'd0, valid_out}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset.valid", {31'd0, valid_out}, 32'd0);
        check("async_reset.rs1",   rs1_data, 32'd0);
        check("async_reset.pc",    PC_out,   32'd0);
        @(negedge clk);
        rst = 1'b1;
        // x5 was cleared by reset; capture resumes on the first edge.
        step(32'h0002_8113, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("after_reset", 32'h0, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h30, 1'b1));
        // Bubble: fields captured, valid_out low.
        step(32'h0002_8113, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             mk("bubble", 32'h0, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 7'h00, 32'h34, 1'b0));

        apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
